q2_seq_encoder: RTL
===================

Name: q2_seq_encoder

Overview:
- Sequential 16-to-4 encoder; the inverse of the q2 4-to-16 decoder.
- Captures a 16-bit request vector Y[0:15]. Y[0] corresponds to decoder code 0.
- Emits the 4-bit code of every set bit, one code per accepted handshake, lowest index first.
- Used to turn decoded select lines back into binary codes for downstream logic and benches.

Parameters:
- W, 4, code width.
- N, 16, request vector width; must equal 2**W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- En  input  1  enable; load is honoured only when En=1
- load  input  1  capture Y this cycle (IDLE only)
- Y  input  [0:N-1]  request vector; Y[i]=1 requests code i
- ready  input  1  downstream accepts D this cycle
- D  output  [W-1:0]  encoded index, valid when valid=1
- valid  output  1  D holds a code
- busy  output  1  vector captured and not yet drained
- done  output  1  one-cycle pulse after the last code is accepted
- none  output  1  one-cycle pulse when a load captured an all-zero vector

Behaviour:
- Reset: synchronous, evaluated on the clk rising edge when rst=1; overrides all other inputs.
  - State=IDLE, pending=0, D=0, valid=0, busy=0, done=0, none=0.
- All outputs are registered. Internal pending register is [0:N-1].
- IDLE state:
  - load=1, En=1, Y!=0: pending<=Y, busy<=1, go EMIT.
  - load=1, En=1, Y==0: none<=1 for one cycle; stay IDLE; busy stays 0.
  - load=0 or En=0: no action.
- EMIT state:
  - valid=1; D = smallest i with pending[i]=1.
  - D and valid appear the cycle after load (latency 1 from load to first valid).
  - valid=1, ready=0: D and valid hold stable; no bit is cleared.
  - valid=1, ready=1: clear pending[D].
    - Bits remain: next cycle D = next set index, valid stays 1. Back-to-back throughput is one code per cycle.
    - No bits remain: next cycle valid<=0, busy<=0, done<=1 for one cycle, D holds last value, go IDLE.
- load during EMIT is ignored; the captured vector is not modified.
- En is sampled only at load; dropping En during EMIT does not stop draining.
- A new load is accepted in the same cycle done is high, because the FSM is already in IDLE.
- Reset mid-EMIT discards pending codes; no done pulse is generated.
- Boundaries:
  - Y=16'hFFFF emits 0..15 in order.
  - A single-bit Y emits exactly one code, then done.
- Codes are always in range 0..N-1; no wrap-around.

Optional Feature:
- Macro: Q2_ENC_COUNT_EN.
- Defined:
  - Adds output cnt [W:0], 5 bits, range 0..16.
  - On an accepted load (En=1), cnt is loaded with the popcount of Y, including 0 for an all-zero vector.
  - cnt decrements by 1 on each valid&&ready.
  - Reset value 0; cnt reads 0 in the cycle done is high.
- Undefined: no cnt port and no popcount logic; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with load=1, Y=16'hFFFF -> D=0, valid=0, busy=0, done=0, none=0 throughout and after release.
- En=1, load Y=1<<(15-5) (only Y[5]), ready=1 -> next cycle D=5, valid=1; following cycle valid=0, done=1, busy=0.
- En=1, load Y with bits 2, 9, 15 set, ready=1 -> D=2,9,15 on consecutive cycles, then done.
  - Repeat with ready=0 for 3 cycles on code 9: D holds 9 and valid stays 1 until ready.
- En=1, load Y=16'hFFFF, ready=1 -> D=0..15 over 16 cycles, done on cycle 17.
  - A second load during draining is ignored.
  - With Q2_ENC_COUNT_EN: cnt=16 after load, then 15..0.
- En=0, load Y=16'h00FF -> no valid, busy=0. Then En=1, load Y=0 -> none=1 for one cycle, valid stays 0.
- Reset mid-drain: load 16'hFFFF, assert rst at code 7 -> valid=0, busy=0, no done.
  - Then load Y[3] only -> D=3 emitted.

Source files
------------

// File: rtl/q2_seq_encoder.sv
// rtl/q2_seq_encoder.sv - sequential 16-to-4 encoder, emits one code per handshake, lowest index first
// Optional macro Q2_ENC_COUNT_EN adds the cnt output (codes still to be accepted).
module q2_seq_encoder #(
  parameter int W = 4,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         En,
  input  logic         load,
  input  logic [0:N-1] Y,
  input  logic         ready,
  output logic [W-1:0] D,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         none
`ifdef Q2_ENC_COUNT_EN
  ,
  output logic [W:0]   cnt
`endif
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t       state_q, state_d;
  logic [0:N-1] pending_q, pending_d;
  logic [W-1:0] d_q, d_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         none_q, none_d;
  logic [0:N-1] pending_clr;
  logic         accept;
  logic         load_ok;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  function automatic logic [W-1:0] first_set(input logic [0:N-1] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

`ifdef Q2_ENC_COUNT_EN
  logic [W:0] cnt_q, cnt_d;

  function automatic logic [W:0] popcount(input logic [0:N-1] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction
`endif

  // Handshake qualifiers and the pending vector with the current code removed.
  always_comb begin
    load_ok     = load && En;
    accept      = (state_q == S_EMIT) && valid_q && ready;
    pending_clr = pending_q;
    pending_clr[d_q] = 1'b0;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      d_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      none_q    <= 1'b0;
`ifdef Q2_ENC_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      d_q       <= d_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      none_q    <= none_d;
`ifdef Q2_ENC_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next state: leave IDLE on a non-empty load, return once the last code is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_ok && (Y != '0)) state_d = S_EMIT;
      S_EMIT:  if (accept && (pending_clr == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; D holds its last code after draining.
  always_comb begin
    pending_d = pending_q;
    d_d       = d_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    none_d    = 1'b0;
`ifdef Q2_ENC_COUNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_ok) begin
`ifdef Q2_ENC_COUNT_EN
          cnt_d = popcount(Y);
`endif
          if (Y != '0) begin
            pending_d = Y;
            d_d       = first_set(Y);
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (accept) begin
          pending_d = pending_clr;
`ifdef Q2_ENC_COUNT_EN
          cnt_d     = cnt_q - 1'b1;
`endif
          if (pending_clr != '0) begin
            d_d = first_set(pending_clr);
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign D     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign none  = none_q;
`ifdef Q2_ENC_COUNT_EN
  assign cnt   = cnt_q;
`endif

endmodule
